instr_cache_ctrl: RTL
=====================

Name: instr_cache_ctrl

Overview:
- Direct-mapped instruction cache that sits between the PC register and main memory.
- Drives `hit` to the PC register. The PC loads its next value on the falling clock edge only while `hit` is 1.
- On a miss it stalls the PC (`hit` = 0), refills the whole line from memory with a word-by-word request/ready handshake, then resumes the lookup.
- All cache state updates on the rising edge of `clock`. `hit` and `instruction` are settled before the falling edge the PC samples on.

Parameters:
- LINES, 16, number of cache lines (power of 2, ≥ 2).
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2, ≥ 2).
- Derived, not overridable:
  - OFF_W = log2(WORDS_PER_LINE)
  - IDX_W = log2(LINES)
  - TAG_W = 30 − OFF_W − IDX_W

Ports:
- clock, input, 1, system clock; state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- pc, input, 32, byte address of the fetch; bits [1:0] are ignored.
- flush, input, 1, single-cycle pulse that invalidates all lines.
- hit, output, 1, combinational; 1 = `instruction` is valid and the PC may advance.
- instruction, output, 32, fetched word; 0 whenever `hit` = 0.
- mem_req, output, 1, word read request to memory.
- mem_addr, output, 32, word-aligned byte address of the requested word.
- mem_ready, input, 1, memory returns `mem_rdata` this cycle.
- mem_rdata, input, 32, memory read data.

Behaviour:
- Clock and reset: one clock domain, `clock`. `reset` is synchronous and active-high.
- Address split of `pc`:
  - offset = pc[OFF_W+1:2]
  - index = pc[OFF_W+IDX_W+1:OFF_W+2]
  - tag = pc[31:OFF_W+IDX_W+2]
  - Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage: per line, one valid bit, a TAG_W-bit tag, and WORDS_PER_LINE data words. The data array is not reset.
- On reset:
  - all valid bits = 0, state = LOOKUP
  - mem_req = 0, mem_addr = 0, word counter = 0
  - Reset wins over every other input in the same cycle.
- FSM state LOOKUP:
  - hit = valid[index] && tag_array[index] == tag, combinational from `pc`.
  - When hit = 1: instruction = data[index][offset].
  - Miss at a rising edge: latch line base address = {pc[31:OFF_W+2], OFF_W+2 zero bits}; word counter = 0; mem_req = 1; mem_addr = line base; go to FILL.
- FSM state FILL:
  - hit = 0, instruction = 0.
  - mem_req stays 1; mem_addr = line base + 4 × counter.
  - Rising edge with mem_ready = 1: data[latched index][counter] = mem_rdata.
    - If counter < WORDS_PER_LINE − 1: counter++.
    - If counter = WORDS_PER_LINE − 1: set tag and valid for the latched index; mem_req = 0; go to LOOKUP.
  - mem_ready = 0: hold all state; no timeout.
  - `pc` is ignored during FILL (the PC is frozen by hit = 0). The fill always uses the latched address.
- Post-fill latency: the first LOOKUP cycle after a fill re-evaluates `pc` and hits.
- Miss penalty: 1 + WORDS_PER_LINE cycles with zero-wait memory, assuming the cycle after a fill hits.
- flush:
  - In LOOKUP: all valid bits cleared at that edge; no fill starts in that cycle.
  - In FILL: the fill is aborted; mem_req = 0; all valid bits cleared, including the line being filled; go to LOOKUP.
- Reset mid-FILL: the fill is aborted and the line remains invalid. A late mem_ready after reset is ignored.
- Conflict: a different tag at the same index replaces the line; no write-back is needed (read-only cache).
- mem_addr[1:0] is always 0.

Test Plan:
- Cold miss: reset, then pc = 0x00000040.
  - hit = 0; mem_req = 1 with mem_addr 0x40, 0x44, 0x48, 0x4C on successive ready cycles.
  - Memory returns 0xA0..0xA3; the next cycle hit = 1 and instruction = 0xA0.
- Same-line hits: after the fill, pc = 0x44, 0x48, 0x4C → hit = 1 each cycle, instruction = 0xA1, 0xA2, 0xA3, mem_req = 0.
- Wait states: miss at pc = 0x100 with mem_ready low for 3 cycles before each word.
  - mem_addr holds each value until its ready; hit stays 0 throughout.
  - Total stall = 4 words × 4 cycles + 1 = 17 cycles.
- Conflict: fill 0x40, then pc = 0x140 (same index 4, tag differs).
  - Miss; refill from 0x140.
  - A return to pc = 0x40 misses again.
- Flush / reset mid-fill:
  - flush pulse after word 2 of a fill: mem_req drops the next cycle; the same pc then re-misses and refetches from word 0.
  - The same test with reset instead of flush gives the same result.
- Flush in LOOKUP: flush while pc = 0x44 hits → the next cycle hit = 0 and a fill starts at 0x40.

Source files
------------

// File: rtl/instr_cache_ctrl_if.sv
// Fetch-side and memory-side signals of the instruction cache controller.
// The cache itself connects through the slave modport.
interface instr_cache_ctrl_if;
  logic [31:0] pc;
  logic        flush;
  logic        hit;
  logic [31:0] instruction;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output pc, flush, mem_ready, mem_rdata,
    input  hit, instruction, mem_req, mem_addr
  );

  modport slave (
    input  pc, flush, mem_ready, mem_rdata,
    output hit, instruction, mem_req, mem_addr
  );
endinterface

// File: rtl/instr_cache_ctrl.sv
// Direct-mapped read-only instruction cache; a miss stalls the PC and refills
// the whole line word by word over a request/ready handshake.
//   state  | meaning
//   LOOKUP | combinational tag compare on pc, start a fill on a miss
//   FILL   | fetching words of the latched line, hit forced low
module instr_cache_ctrl #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input logic               clock,
  input logic               reset,
  instr_cache_ctrl_if.slave bus
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = 30 - OFF_W - IDX_W;
  localparam int BASE_W = 30 - OFF_W;
  localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

  localparam logic [0:0] LOOKUP = 1'b0;
  localparam logic [0:0] FILL   = 1'b1;

  logic [0:0]        state;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_array [LINES];
  logic [31:0]       data_array [LINES*WORDS_PER_LINE];
  logic [BASE_W-1:0] line_base;
  logic [OFF_W-1:0]  word_cnt;
  logic              mem_req_q;

  logic [OFF_W-1:0] pc_off;
  logic [IDX_W-1:0] pc_idx;
  logic [TAG_W-1:0] pc_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             lookup_hit;
  logic             word_wr;
  logic             line_done;

  assign pc_off   = bus.pc[OFF_W+1:2];
  assign pc_idx   = bus.pc[OFF_W+IDX_W+1:OFF_W+2];
  assign pc_tag   = bus.pc[31:OFF_W+IDX_W+2];
  assign fill_idx = line_base[IDX_W-1:0];
  assign fill_tag = line_base[BASE_W-1:IDX_W];

  assign lookup_hit = (state == LOOKUP) && valid[pc_idx] && (tag_array[pc_idx] == pc_tag);

  assign bus.hit         = lookup_hit;
  assign bus.instruction = lookup_hit ? data_array[{pc_idx, pc_off}] : 32'h0;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = {line_base, word_cnt, 2'b00};

  // Flush and reset both abort a fill, so neither may write the arrays.
  assign word_wr   = (state == FILL) && !reset && !bus.flush && bus.mem_ready;
  assign line_done = word_wr && (word_cnt == LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= LOOKUP;
      valid     <= '0;
      mem_req_q <= 1'b0;
      line_base <= '0;
      word_cnt  <= '0;
    end else begin
      case (state)
        LOOKUP: begin
          if (bus.flush) begin
            valid <= '0;
          end else if (!lookup_hit) begin
            line_base <= bus.pc[31:OFF_W+2];
            word_cnt  <= '0;
            mem_req_q <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (bus.flush) begin
            valid     <= '0;
            mem_req_q <= 1'b0;
            state     <= LOOKUP;
          end else if (bus.mem_ready) begin
            if (word_cnt == LAST) begin
              valid[fill_idx] <= 1'b1;
              mem_req_q       <= 1'b0;
              state           <= LOOKUP;
            end else begin
              word_cnt <= word_cnt + OFF_W'(1);
            end
          end
        end
        default: state <= LOOKUP;
      endcase
    end
  end

  // Storage arrays carry no reset; valid bits alone qualify their contents.
  always_ff @(posedge clock) begin
    if (word_wr) data_array[{fill_idx, word_cnt}] <= bus.mem_rdata;
    if (line_done) tag_array[fill_idx] <= fill_tag;
  end
endmodule
